// File: rtl/muldiv_iter_if.sv
// Handshake and operand bundle between the EX stage and the iterative
// multiply/divide unit. The master (EX) drives the request side, the slave
// (muldiv_iter) returns busy/ready, the result and the divide-by-zero flag.
interface muldiv_iter_if #(
    parameter int WIDTH = 32
) ();
    logic                   start_i;
    logic [1:0]             op_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic                   annul_i;
    logic                   busy_o;
    logic                   ready_o;
    logic [2*WIDTH-1:0]     result_o;
    logic                   div_by_zero_o;

    modport master (
        output start_i, op_i, opdata1_i, opdata2_i, annul_i,
        input  busy_o, ready_o, result_o, div_by_zero_o
    );

    modport slave (
        input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
        output busy_o, ready_o, result_o, div_by_zero_o
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit, one bit per cycle.
// Multiply is shift-add on a 2W accumulator {hi, lo}, with the multiplier
// held in lo and consumed from the LSB. Divide is restoring division on the
// same accumulator viewed as {rem, quot}. Signed operands are reduced to
// magnitudes on accept and the signs are re-applied on the final step.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    muldiv_iter_if.slave    bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_is_div;
    logic                   r_neg_res;
    logic                   r_neg_rem;
    logic [2*WIDTH-1:0]     r_acc;     // mul: {hi, multiplier}; div: {rem, quot}
    logic [WIDTH-1:0]       r_opb;     // mul: multiplicand; div: divisor
    logic [2*WIDTH-1:0]     r_result;
    logic                   r_ready;
    logic                   r_busy;
    logic                   r_dbz;

    logic                   w_s1;
    logic                   w_s2;
    logic [WIDTH-1:0]       w_mag1;
    logic [WIDTH-1:0]       w_mag2;
    logic                   w_div_zero;

    logic [WIDTH:0]         w_mul_sum;
    logic [2*WIDTH-1:0]     w_mul_next;
    logic [WIDTH:0]         w_div_sh;
    logic [WIDTH+1:0]       w_div_diff;
    logic [2*WIDTH-1:0]     w_div_next;
    logic [2*WIDTH-1:0]     w_step;
    logic [WIDTH-1:0]       w_quot_raw;
    logic [WIDTH-1:0]       w_rem_raw;
    logic [2*WIDTH-1:0]     w_final;

    // Operand conditioning: signs only count in signed mode; most-negative
    // maps onto its own bit pattern, which is the correct unsigned magnitude.
    assign w_s1       = bus.op_i[0] & bus.opdata1_i[WIDTH-1];
    assign w_s2       = bus.op_i[0] & bus.opdata2_i[WIDTH-1];
    assign w_mag1     = w_s1 ? -bus.opdata1_i : bus.opdata1_i;
    assign w_mag2     = w_s2 ? -bus.opdata2_i : bus.opdata2_i;
    assign w_div_zero = bus.op_i[1] && (bus.opdata2_i == '0);

    // One iteration of either algorithm, selected by the latched operation.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
        // Carry bit lands in the top of the accumulator after the right shift.
        w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

        // Partial remainder after the left shift, W+1 bits wide.
        w_div_sh   = r_acc[2*WIDTH-1:WIDTH-1];
        w_div_diff = {1'b0, w_div_sh} - {2'b00, r_opb};
        if (w_div_diff[WIDTH+1]) begin
            // Negative trial: restore. Bit W of the shifted remainder is 0 here.
            w_div_next = {w_div_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end else begin
            w_div_next = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end

        w_step = r_is_div ? w_div_next : w_mul_next;
    end

    // Sign correction applied to the value produced by the last iteration.
    always_comb begin
        w_quot_raw = w_step[WIDTH-1:0];
        w_rem_raw  = w_step[2*WIDTH-1:WIDTH];
        if (r_is_div) begin
            w_final[WIDTH-1:0]       = r_neg_res ? -w_quot_raw : w_quot_raw;
            w_final[2*WIDTH-1:WIDTH] = r_neg_rem ? -w_rem_raw : w_rem_raw;
        end else begin
            w_final = r_neg_res ? -w_step : w_step;
        end
    end

    // Control FSM with all outputs registered alongside the datapath state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_acc     <= '0;
            r_opb     <= '0;
            r_result  <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i && !bus.annul_i) begin
                        r_is_div  <= bus.op_i[1];
                        r_neg_res <= w_s1 ^ w_s2;
                        r_neg_rem <= w_s1;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        if (bus.op_i[1]) begin
                            r_acc <= {{WIDTH{1'b0}}, w_mag1};
                            r_opb <= w_mag2;
                        end else begin
                            r_acc <= {{WIDTH{1'b0}}, w_mag2};
                            r_opb <= w_mag1;
                        end
                        if (w_div_zero) begin
                            // No iterations needed; report straight away.
                            r_state  <= S_DONE;
                            r_result <= {bus.opdata1_i, {WIDTH{1'b1}}};
                            r_dbz    <= 1'b1;
                            r_ready  <= 1'b1;
                        end else begin
                            r_state  <= S_CALC;
                            r_dbz    <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    if (bus.annul_i) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(WIDTH - 1)) begin
                            r_state  <= S_DONE;
                            r_result <= w_final;
                            r_ready  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // Single-cycle ready; annul here changes nothing further.
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o        = r_busy;
    assign bus.ready_o       = r_ready;
    assign bus.result_o      = r_result;
    assign bus.div_by_zero_o = r_dbz;

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Parametrised iterative multiply/divide unit for the EX stage. It replaces the separate `mul`/`div` instances with one shared datapath that handles signed and unsigned multiply and divide at any operand width. It runs one bit per cycle behind a start/ready handshake, with annul and explicit divide-by-zero reporting. EX drives it and holds `stallreq_for_ex` high while `busy_o` is set.

## Interface
- `WIDTH`, default 32: operand width in bits. Must be ≥ 4. Result width is 2*WIDTH.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous reset, active-high
- `start_i`  in  1  request an operation. Sampled only in IDLE.
- `op_i`  in  2  operation select: [1] = 1 divide, 0 multiply; [0] = 1 signed, 0 unsigned
- `opdata1_i`  in  WIDTH  multiplicand / dividend
- `opdata2_i`  in  WIDTH  multiplier / divisor
- `annul_i`  in  1  abort the operation in progress; no result is produced
- `busy_o`  out  1  high in CALC and DONE
- `ready_o`  out  1  one-cycle pulse; `result_o` is valid
- `result_o`  out  2*WIDTH  multiply: {hi, lo} product; divide: {remainder, quotient}
- `div_by_zero_o`  out  1  valid with `ready_o`; high only for a divide with divisor 0

## Operation
- States: IDLE, CALC, DONE. Counter `cnt` is $clog2(WIDTH)+1 bits wide.
- IDLE, with `start_i`=1 and `annul_i`=0:
  - Latch `op_i`.
  - Latch |opdata1| and |opdata2|. Magnitudes are taken only if `op_i[0]`=1; otherwise the raw values are used.
  - Latch sign bits: neg_res = s1^s2 and neg_rem = s1 (signed mode only).
  - Divide with `opdata2_i`=0: go to DONE directly. Set `result_o` = {opdata1_i, {WIDTH{1'b1}}} and `div_by_zero_o`=1.
  - Otherwise: go to CALC, `cnt`=0.
- IDLE, with `start_i`=0 or `annul_i`=1: remain in IDLE.
- CALC, multiply (shift-add): per cycle, if multiplier LSB = 1, add the multiplicand into the upper half of the 2W accumulator (W+1-bit carry). Then shift the accumulator right by 1.
- CALC, divide (restoring): per cycle, shift {rem, quot} left by 1, then trial-subtract the divisor from the W+1-bit partial remainder.
  - Non-negative: keep the difference and set quot LSB = 1.
  - Negative: restore the partial remainder.
- CALC: `cnt` increments every cycle. When `cnt`==WIDTH-1, the final step completes and the state moves to DONE.
- On entering DONE from CALC, sign-correct and register `result_o`:
  - Multiply: 2W-bit product, negated if neg_res.
  - Divide: quotient negated if neg_res; remainder negated if neg_rem.
- DONE: `ready_o`=1 for exactly one cycle, then return to IDLE unconditionally.
- `result_o` holds its value until the next accepted start overwrites it in DONE. `div_by_zero_o` clears on the next accepted start.
- Signed overflow (most-negative / −1): quotient wraps to most-negative, remainder 0. No trap.
- `annul_i`=1 in CALC or DONE: go to IDLE next edge. No `ready_o` pulse; `result_o` keeps its previous value.
- `start_i` while busy is ignored; no queuing.
- Reset (any time, including mid-CALC): state IDLE; `cnt`, accumulators, `result_o`, `ready_o`, `div_by_zero_o`, `busy_o` all 0.

## Timing
- Start is accepted at edge E0. Normal operation occupies CALC for edges E1..EWIDTH. `ready_o` is high in the cycle after edge EWIDTH, i.e. latency WIDTH+1 cycles (33 for WIDTH=32).
- Divide by zero: `ready_o` is high in the cycle after E0 (latency 1).
- `busy_o` rises in the cycle after E0 and falls in the cycle after `ready_o`. Back-to-back start is possible on the first IDLE cycle.
- All outputs are registered; no combinational path from inputs to outputs.
- `annul_i` takes effect at the next edge. If `annul_i` is asserted in the DONE cycle itself, `ready_o` is still visible that cycle; EX must ignore it.

## Test plan
- WIDTH=32, unsigned mul 0xFFFFFFFF×0xFFFFFFFF → `result_o`=0xFFFFFFFE_00000001, `ready_o` exactly 33 cycles after start, one cycle wide.
- Signed mul −3×5 → 0xFFFFFFFF_FFFFFFF1. Unsigned mul 0xFFFFFFFD×5 → 0x00000004_FFFFFFF1.
- Signed div −7/2 → quot 0xFFFFFFFD, rem 0xFFFFFFFF. Unsigned div 0xFFFFFFF9/2 → quot 0x7FFFFFFC, rem 1. Signed 0x80000000/0xFFFFFFFF → quot 0x80000000, rem 0.
- Div 5/0 (signed and unsigned) → `ready_o` one cycle after start, `div_by_zero_o`=1, `result_o`={0x00000005, 0xFFFFFFFF}. Next start clears `div_by_zero_o`.
- Start a div, assert `annul_i` at cycle 10 → IDLE next cycle, no `ready_o`, `result_o` unchanged. New mul accepted the following cycle gives the correct product.
- `rst` asserted asynchronously mid-CALC (between edges) → all outputs 0 immediately. After release, start is ignored while busy, and a fresh op completes correctly. Repeat the mul/div tests with WIDTH=8.
